e203_ifu_bht_bpu: RTL and testbench
===================================

// Module: e203_ifu_bht_bpu
// PURPOSE
//  IFU branch-prediction stage. It sits directly downstream of the IFU mini-decoder and consumes its
//  dec_jal/dec_jalr/dec_bxx/dec_bjp_imm/dec_jalr_rs1idx outputs, plus the PC of the same instruction.
//  It produces the taken prediction and the two PC-adder operands for the next fetch.
//  Conditional branches use a 2-bit saturating-counter BHT, trained at EXU resolve.
//  JALR obtains rs1 from x0, from forwarded x1, or via a one-cycle regfile read through a shared port.
// PARAMETERS
//  BHT_IDX_W   6    BHT index width; BHT holds 2**BHT_IDX_W 2-bit counters, index = pc[BHT_IDX_W+1:2]
//  PC_W        32   PC / operand width (=`E203_PC_SIZE)
// PORTS
//  clk              in   1     core clock
//  rst              in   1     synchronous, active-high reset
//  flush            in   1     pipeline flush; cancels any in-progress lookup
//  req_valid        in   1     decoded instruction present (held until req_ready)
//  req_ready        out  1     prediction complete this cycle
//  req_pc           in   PC_W  PC of the decoded instruction
//  dec_jal          in   1     from mini-decoder
//  dec_jalr         in   1     from mini-decoder
//  dec_bxx          in   1     from mini-decoder
//  dec_bjp_imm      in   PC_W  sign-extended branch/jump immediate
//  dec_jalr_rs1idx  in   5     JALR rs1 index
//  x1_val           in   PC_W  forwarded x1 value
//  x1_dep           in   1     outstanding write to x1 in flight
//  rs1_port_busy    in   1     shared regfile read port in use by the IR stage
//  rs1_dep          in   1     outstanding write to the JALR rs1 register
//  bpu2rf_rs1_ena   out  1     one-cycle read request on the shared port
//  rf2bpu_rs1       in   PC_W  read data, valid the cycle after bpu2rf_rs1_ena
//  prdt_taken       out  1     predicted taken; valid when req_valid&req_ready
//  prdt_op1         out  PC_W  PC-adder operand 1
//  prdt_op2         out  PC_W  PC-adder operand 2
//  upd_valid        in   1     EXU branch resolved (bxx only)
//  upd_pc           in   PC_W  PC of the resolved branch
//  upd_taken        in   1     actual outcome
// BEHAVIOUR
//  Reset: FSM=IDLE; all BHT counters=2'b01 (weak not-taken); bpu2rf_rs1_ena=0; rs1 capture reg=0.
//  Reset mid-operation returns to IDLE; any pending read is discarded.
//  Non-bjp instruction: ready=1, prdt_taken=0, op1=req_pc, op2=4.
//  JAL: ready=1, taken=1, op1=req_pc, op2=imm.
//  BXX: ready=1, taken=bht[idx][1], op1=req_pc, op2 = taken ? imm : 4.
//  JALR rs1=x0: ready=1, taken=1, op1=0, op2=imm.
//  JALR rs1=x1: ready=!x1_dep, taken=1, op1=x1_val, op2=imm.
//  JALR rs1=xN: FSM handles it.
//   IDLE    -> RS1_RD  when !rs1_dep & !rs1_port_busy; assert rs1_ena this cycle; ready=0.
//   RS1_RD  -> DONE    capture rf2bpu_rs1; ready=0.
//   DONE    -> IDLE    ready=1; op1=captured value; op2=imm; taken=1.
//   While rs1_dep or rs1_port_busy, stay IDLE with ready=0 and rs1_ena=0.
//  flush: forces IDLE next cycle, ready=0, rs1_ena=0 in the flush cycle; BHT is not reset.
//  All adds are done externally; operands are PC_W wide and are not truncated here.
//  BHT update (registered, takes effect next cycle):
//   counter at upd_pc index increments if taken, else decrements; saturates at 2'b11 and 2'b00.
//  A same-cycle lookup and update to the same index sees the OLD counter value.
//  Update and lookup to different indices are independent. Lookups never modify the BHT.
// TESTING
//  1. After reset, bxx at pc=0x100 with imm=0x40 -> taken=0, op1=0x100, op2=4, ready=1 in the same cycle.
//  2. Three upd_taken=1 at pc 0x100, then bxx lookup -> taken=1, op2=0x40.
//     Then four more taken updates, then one not-taken update -> still taken (saturated at 11, now 10).
//  3. Aliasing check (BHT_IDX_W=6): update pc=0x100 taken x2; lookup pc=0x200 -> taken=1 (same index).
//     Lookup pc=0x104 -> taken=0.
//  4. JALR rs1=x5, rs1_port_busy=1 for 2 cycles -> ready=0 and rs1_ena=0 for those cycles.
//     Then rs1_ena pulses 1 cycle; rf2bpu_rs1=0x8000 next cycle; ready=1 one cycle later with op1=0x8000.
//  5. JALR rs1=x1 with x1_dep=1 for 3 cycles then 0, x1_val=0x2000, imm=-4 -> ready rises in cycle 4.
//     op2=0xFFFFFFFC, taken=1.
//  6. flush asserted in RS1_RD -> IDLE next cycle, no ready pulse, captured data discarded.
//     Same-cycle upd and lookup on one index -> lookup returns the pre-update value.

Source files
------------

// File: rtl/e203_ifu_bht_bpu.sv
// IFU branch-prediction stage: static/BHT taken prediction plus PC-adder operands for the next fetch.
// JALR rs1 comes from x0, forwarded x1, or a one-cycle read on the shared regfile port.
module e203_ifu_bht_bpu #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PC_W-1:0] req_pc,
  input  logic            dec_jal,
  input  logic            dec_jalr,
  input  logic            dec_bxx,
  input  logic [PC_W-1:0] dec_bjp_imm,
  input  logic [4:0]      dec_jalr_rs1idx,
  input  logic [PC_W-1:0] x1_val,
  input  logic            x1_dep,
  input  logic            rs1_port_busy,
  input  logic            rs1_dep,
  output logic            bpu2rf_rs1_ena,
  input  logic [PC_W-1:0] rf2bpu_rs1,
  output logic            prdt_taken,
  output logic [PC_W-1:0] prdt_op1,
  output logic [PC_W-1:0] prdt_op2,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken
);

  localparam int unsigned BhtDepth = 2 ** BHT_IDX_W;
  localparam logic [PC_W-1:0] Four = PC_W'(4);

  typedef enum logic [1:0] {StIdle, StRs1Rd, StDone} state_e;

  state_e          state_q, state_d;
  logic [1:0]      bht_q [BhtDepth];
  logic [PC_W-1:0] rs1_q;
  logic [1:0]      upd_cur, upd_nxt;
  logic            bxx_taken;

  logic [BHT_IDX_W-1:0] lkp_idx, upd_idx;
  assign lkp_idx = req_pc[BHT_IDX_W+1:2];
  assign upd_idx = upd_pc[BHT_IDX_W+1:2];

  // Only the index bits of the update PC matter.
  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc[PC_W-1:BHT_IDX_W+2], upd_pc[1:0]};

  // Saturating 2-bit counter step.
  always_comb begin
    upd_cur = bht_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken && (upd_cur != 2'b11)) begin
      upd_nxt = upd_cur + 2'b01;
    end else if (!upd_taken && (upd_cur != 2'b00)) begin
      upd_nxt = upd_cur - 2'b01;
    end
  end

  assign bxx_taken = bht_q[lkp_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rs1_q   <= '0;
      for (int i = 0; i < BhtDepth; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == StRs1Rd) && !flush) begin
        rs1_q <= rf2bpu_rs1;
      end
      if (upd_valid) begin
        bht_q[upd_idx] <= upd_nxt;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    prdt_taken     = 1'b0;
    prdt_op1       = req_pc;
    prdt_op2       = Four;
    bpu2rf_rs1_ena = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dec_jal) begin
          req_ready  = 1'b1;
          prdt_taken = 1'b1;
          prdt_op2   = dec_bjp_imm;
        end else if (dec_jalr) begin
          prdt_taken = 1'b1;
          prdt_op2   = dec_bjp_imm;
          if (dec_jalr_rs1idx == 5'd0) begin
            prdt_op1  = '0;
            req_ready = 1'b1;
          end else if (dec_jalr_rs1idx == 5'd1) begin
            prdt_op1  = x1_val;
            req_ready = !x1_dep;
          end else if (req_valid && !rs1_dep && !rs1_port_busy) begin
            bpu2rf_rs1_ena = 1'b1;
            state_d        = StRs1Rd;
          end
        end else if (dec_bxx) begin
          req_ready  = 1'b1;
          prdt_taken = bxx_taken;
          prdt_op2   = bxx_taken ? dec_bjp_imm : Four;
        end else begin
          req_ready = 1'b1;
        end
      end
      StRs1Rd: begin
        prdt_taken = 1'b1;
        prdt_op2   = dec_bjp_imm;
        state_d    = StDone;
      end
      StDone: begin
        req_ready  = 1'b1;
        prdt_taken = 1'b1;
        prdt_op1   = rs1_q;
        prdt_op2   = dec_bjp_imm;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush drops the in-progress lookup; BHT contents survive.
    if (flush) begin
      state_d        = StIdle;
      req_ready      = 1'b0;
      bpu2rf_rs1_ena = 1'b0;
    end
    if (rst) begin
      bpu2rf_rs1_ena = 1'b0;
    end
  end

endmodule

// File: tb/tb_e203_ifu_bht_bpu.sv
// Directed bench for e203_ifu_bht_bpu: decode cases, BHT training/saturation/aliasing, JALR paths.
module tb_e203_ifu_bht_bpu;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready;
  logic [31:0] req_pc, dec_bjp_imm, x1_val, rf2bpu_rs1, prdt_op1, prdt_op2, upd_pc;
  logic        dec_jal, dec_jalr, dec_bxx, x1_dep, rs1_port_busy, rs1_dep;
  logic [4:0]  dec_jalr_rs1idx;
  logic        bpu2rf_rs1_ena, prdt_taken, upd_valid, upd_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  e203_ifu_bht_bpu #(.BHT_IDX_W(6), .PC_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .dec_jal        (dec_jal),
    .dec_jalr       (dec_jalr),
    .dec_bxx        (dec_bxx),
    .dec_bjp_imm    (dec_bjp_imm),
    .dec_jalr_rs1idx(dec_jalr_rs1idx),
    .x1_val         (x1_val),
    .x1_dep         (x1_dep),
    .rs1_port_busy  (rs1_port_busy),
    .rs1_dep        (rs1_dep),
    .bpu2rf_rs1_ena (bpu2rf_rs1_ena),
    .rf2bpu_rs1     (rf2bpu_rs1),
    .prdt_taken     (prdt_taken),
    .prdt_op1       (prdt_op1),
    .prdt_op2       (prdt_op2),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = 0; req_pc = '0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_bjp_imm = '0; dec_jalr_rs1idx = '0; x1_dep = 0; rs1_port_busy = 0; rs1_dep = 0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; flush = 0; rf2bpu_rs1 = '0; x1_val = '0;
  endtask

  task automatic do_reset();
    clear_req();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic bxx(input logic [31:0] pc, input logic [31:0] imm);
    clear_req();
    req_valid = 1; dec_bxx = 1; req_pc = pc; dec_bjp_imm = imm;
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input int n);
    clear_req();
    for (int i = 0; i < n; i++) begin
      upd_valid = 1; upd_pc = pc; upd_taken = tk;
      step();
    end
    upd_valid = 0;
  endtask

  task automatic jalr_xn(input logic [31:0] pc, input logic [31:0] imm);
    clear_req();
    req_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 5'd5; req_pc = pc; dec_bjp_imm = imm;
  endtask

  initial begin
    // Reset holds the read request low even with a JALR xN pending.
    clear_req();
    rst = 1;
    jalr_xn(32'h500, 32'h20);
    #1;
    chk("rst_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    step();
    rst = 0;
    clear_req();

    // 1: reset counters are weak not-taken
    bxx(32'h100, 32'h40);
    chk("t1_taken", {31'b0, prdt_taken}, 32'd0);
    chk("t1_op1", prdt_op1, 32'h100);
    chk("t1_op2", prdt_op2, 32'd4);
    chk("t1_ready", {31'b0, req_ready}, 32'd1);

    clear_req();
    req_valid = 1; req_pc = 32'h300; dec_bjp_imm = 32'h77; #1;
    chk("nobj_taken", {31'b0, prdt_taken}, 32'd0);
    chk("nobj_op2", prdt_op2, 32'd4);
    chk("nobj_op1", prdt_op1, 32'h300);

    clear_req();
    req_valid = 1; dec_jal = 1; req_pc = 32'h400; dec_bjp_imm = 32'h80; #1;
    chk("jal_taken", {31'b0, prdt_taken}, 32'd1);
    chk("jal_op2", prdt_op2, 32'h80);
    chk("jal_ready", {31'b0, req_ready}, 32'd1);

    clear_req();
    req_valid = 1; dec_jalr = 1; req_pc = 32'h400; dec_bjp_imm = 32'h10; #1;
    chk("x0_op1", prdt_op1, 32'd0);
    chk("x0_op2", prdt_op2, 32'h10);
    chk("x0_ready", {31'b0, req_ready}, 32'd1);
    step();

    // 2: train up, saturate at 11, then walk down to 00 and back
    upd(32'h100, 1'b1, 3);
    bxx(32'h100, 32'h40);
    chk("t2_taken", {31'b0, prdt_taken}, 32'd1);
    chk("t2_op2", prdt_op2, 32'h40);
    upd(32'h100, 1'b1, 4);
    upd(32'h100, 1'b0, 1);
    bxx(32'h100, 32'h40);
    chk("t2_sat_hi", {31'b0, prdt_taken}, 32'd1);
    upd(32'h100, 1'b0, 1);
    bxx(32'h100, 32'h40);
    chk("t2_dn01", {31'b0, prdt_taken}, 32'd0);
    chk("t2_dn01_op2", prdt_op2, 32'd4);
    upd(32'h100, 1'b0, 3);
    upd(32'h100, 1'b1, 1);
    bxx(32'h100, 32'h40);
    chk("t2_sat_lo", {31'b0, prdt_taken}, 32'd0);
    upd(32'h100, 1'b1, 1);
    bxx(32'h100, 32'h40);
    chk("t2_up10", {31'b0, prdt_taken}, 32'd1);

    // 3: aliasing on index bits pc[7:2]
    do_reset();
    upd(32'h100, 1'b1, 2);
    bxx(32'h200, 32'h60);
    chk("t3_alias", {31'b0, prdt_taken}, 32'd1);
    chk("t3_alias_op2", prdt_op2, 32'h60);
    bxx(32'h104, 32'h60);
    chk("t3_other", {31'b0, prdt_taken}, 32'd0);

    // 4: JALR xN blocked by dependency and port busy, then regfile read
    jalr_xn(32'h500, 32'h20);
    rs1_dep = 1; #1;
    chk("t4_dep_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    chk("t4_dep_rdy", {31'b0, req_ready}, 32'd0);
    step();
    rs1_dep = 0;
    for (int i = 0; i < 2; i++) begin
      rs1_port_busy = 1; #1;
      chk("t4_busy_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
      chk("t4_busy_rdy", {31'b0, req_ready}, 32'd0);
      step();
    end
    rs1_port_busy = 0; #1;
    chk("t4_ena", {31'b0, bpu2rf_rs1_ena}, 32'd1);
    chk("t4_ena_rdy", {31'b0, req_ready}, 32'd0);
    step();
    rf2bpu_rs1 = 32'h8000; #1;
    chk("t4_rd_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    chk("t4_rd_rdy", {31'b0, req_ready}, 32'd0);
    step();
    rf2bpu_rs1 = 32'hDEAD; #1;
    chk("t4_done_rdy", {31'b0, req_ready}, 32'd1);
    chk("t4_done_op1", prdt_op1, 32'h8000);
    chk("t4_done_op2", prdt_op2, 32'h20);
    chk("t4_done_tk", {31'b0, prdt_taken}, 32'd1);
    step();
    clear_req();

    // 5: JALR x1 waits on x1_dep
    req_valid = 1; dec_jalr = 1; dec_jalr_rs1idx = 5'd1; req_pc = 32'h600;
    dec_bjp_imm = 32'hFFFF_FFFC; x1_val = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      x1_dep = 1; #1;
      chk("t5_wait", {31'b0, req_ready}, 32'd0);
      step();
    end
    x1_dep = 0; #1;
    chk("t5_ready", {31'b0, req_ready}, 32'd1);
    chk("t5_op1", prdt_op1, 32'h2000);
    chk("t5_op2", prdt_op2, 32'hFFFF_FFFC);
    chk("t5_taken", {31'b0, prdt_taken}, 32'd1);
    step();

    // 6: flush during the read discards the captured data
    jalr_xn(32'h700, 32'h30); #1;
    chk("t6_ena", {31'b0, bpu2rf_rs1_ena}, 32'd1);
    step();
    flush = 1; rf2bpu_rs1 = 32'h1234; #1;
    chk("t6_fl_rdy", {31'b0, req_ready}, 32'd0);
    chk("t6_fl_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    step();
    flush = 0; rf2bpu_rs1 = '0; rs1_port_busy = 1; #1;
    chk("t6_idle_rdy", {31'b0, req_ready}, 32'd0);
    chk("t6_idle_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    step();
    rs1_port_busy = 0; #1;
    chk("t6_reena", {31'b0, bpu2rf_rs1_ena}, 32'd1);
    step();
    rf2bpu_rs1 = 32'h5555;
    step();
    #1;
    chk("t6_done_rdy", {31'b0, req_ready}, 32'd1);
    chk("t6_done_op1", prdt_op1, 32'h5555);
    step();

    // Reset in the read state returns to idle
    jalr_xn(32'h700, 32'h30);
    step();
    rst = 1;
    step();
    rst = 0; rs1_port_busy = 1; #1;
    chk("rstmid_rdy", {31'b0, req_ready}, 32'd0);
    chk("rstmid_ena", {31'b0, bpu2rf_rs1_ena}, 32'd0);
    step();

    // Same-cycle update and lookup on one index sees the old counter
    do_reset();
    bxx(32'h100, 32'h40);
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; #1;
    chk("same_old", {31'b0, prdt_taken}, 32'd0);
    step();
    upd_valid = 0; #1;
    chk("same_new", {31'b0, prdt_taken}, 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
